// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl
//   Game-flow sequencer and input arbiter for the dino game.
//   - Turns the raw vsync into a one-cycle frame tick.
//   - Runs the IDLE / RUN / PAUSE / OVER game state machine.
//   - Merges button, keyboard and ultrasonic-ranger requests into one
//     jump/duck command pair per frame.
//   - Keeps the mm:ss BCD run time and the best run time.
//
// Ports
//   clk, rst                   : clock, synchronous active-high reset
//   vsync                      : VGA vsync (clk-synchronous); frame = rising edge
//   start_pulse, pause_pulse   : one-cycle start / pause-toggle requests
//   btn_jump, btn_duck         : debounced button levels (highest priority)
//   kbd_jump, kbd_duck         : keyboard key-held levels
//   distance [19:0], sonic_en  : ranger distance in cm (0 = no echo), enable
//   collision                  : collision level from the game logic
//   game_state [1:0]           : 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
//   game_active                : high iff game_state is RUN
//   frame_tick                 : one-cycle pulse per frame
//   jump_cmd, duck_cmd         : arbitrated commands, held for one frame
//   cmd_src [1:0]              : 0 none, 1 button, 2 keyboard, 3 sonic
//   time_bcd, best_bcd [15:0]  : {min_tens, min_ones, sec_tens, sec_ones}
module dino_game_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int NEAR_CM        = 10,
  parameter int DUCK_CM        = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        start_pulse,
  input  logic        pause_pulse,
  input  logic        btn_jump,
  input  logic        btn_duck,
  input  logic        kbd_jump,
  input  logic        kbd_duck,
  input  logic [19:0] distance,
  input  logic        sonic_en,
  input  logic        collision,
  output logic [1:0]  game_state,
  output logic        game_active,
  output logic        frame_tick,
  output logic        jump_cmd,
  output logic        duck_cmd,
  output logic [1:0]  cmd_src,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd
);

  localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_SEC - 1);
  localparam logic [19:0]      NEAR_D   = 20'(NEAR_CM);
  localparam logic [19:0]      DUCK_D   = 20'(DUCK_CM);
  localparam logic [15:0]      TIME_MAX = 16'h9959;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   game_active_q, game_active_d;

  logic             vsync_q;
  logic             frame_tick_q, frame_tick_d;
  logic             jump_q, jump_d;
  logic             duck_q, duck_d;
  logic [1:0]       src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      time_q, time_d;
  logic [15:0]      best_q, best_d;

  // Decoded control events
  logic clear_run;
  logic run_tick;
  logic enter_over;

  // Arbitration results
  logic       son_ok, son_jump, son_duck;
  logic       arb_jump, arb_duck;
  logic [1:0] arb_src;

  // Advance the BCD mm:ss time by one second, holding at 99:59.
  function automatic logic [15:0] bcd_sec_inc(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (t == TIME_MAX) return t;
    if (so != 4'd9) begin
      so = so + 4'd1;
    end else begin
      so = 4'd0;
      if (st != 4'd5) begin
        st = st + 4'd1;
      end else begin
        st = 4'd0;
        if (mo != 4'd9) begin
          mo = mo + 4'd1;
        end else begin
          mo = 4'd0;
          mt = mt + 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      game_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      game_active_q <= game_active_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_pulse) state_d = S_RUN;
      // A collision on a tick beats a same-cycle pause request.
      S_RUN: begin
        if (frame_tick_q && collision) state_d = S_OVER;
        else if (pause_pulse)          state_d = S_PAUSE;
      end
      S_PAUSE: if (pause_pulse) state_d = S_RUN;
      S_OVER:  if (start_pulse) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs / control decode ----
  always_comb begin
    game_active_d = (state_d == S_RUN);
    clear_run     = ((state_q == S_IDLE) || (state_q == S_OVER)) && start_pulse;
    run_tick      = (state_q == S_RUN) && frame_tick_q;
    enter_over    = (state_q == S_RUN) && (state_d == S_OVER);
  end

  // ---- Request sources and fixed-priority arbitration ----
  always_comb begin
    son_ok   = sonic_en && (distance != 20'd0);
    son_jump = son_ok && (distance < NEAR_D);
    son_duck = son_ok && (distance >= NEAR_D) && (distance < DUCK_D);

    arb_jump = 1'b0;
    arb_duck = 1'b0;
    arb_src  = 2'd0;
    // The winning source supplies both commands; jump wins inside a source.
    if (btn_jump || btn_duck) begin
      arb_jump = btn_jump;
      arb_duck = btn_duck && !btn_jump;
      arb_src  = 2'd1;
    end else if (kbd_jump || kbd_duck) begin
      arb_jump = kbd_jump;
      arb_duck = kbd_duck && !kbd_jump;
      arb_src  = 2'd2;
    end else if (son_jump || son_duck) begin
      arb_jump = son_jump;
      arb_duck = son_duck;
      arb_src  = 2'd3;
    end
  end

  // ---- Frame tick, commands, timer, best time ----
  always_comb begin
    frame_tick_d = vsync && !vsync_q;

    jump_d = jump_q;
    duck_d = duck_q;
    src_d  = src_q;
    // Commands drop on the same edge that leaves RUN.
    if (state_d != S_RUN) begin
      jump_d = 1'b0;
      duck_d = 1'b0;
      src_d  = 2'd0;
    end else if (run_tick) begin
      jump_d = arb_jump;
      duck_d = arb_duck;
      src_d  = arb_src;
    end

    cnt_d  = cnt_q;
    time_d = time_q;
    if (clear_run) begin
      cnt_d  = '0;
      time_d = 16'h0000;
    end else if (run_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        time_d = bcd_sec_inc(time_q);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // BCD digits are ordered most-significant first, so a plain unsigned
    // compare orders run times correctly.
    best_d = best_q;
    if (enter_over && (time_q > best_q)) best_d = time_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      jump_q       <= 1'b0;
      duck_q       <= 1'b0;
      src_q        <= 2'd0;
      cnt_q        <= '0;
      time_q       <= 16'h0000;
      best_q       <= 16'h0000;
    end else begin
      vsync_q      <= vsync;
      frame_tick_q <= frame_tick_d;
      jump_q       <= jump_d;
      duck_q       <= duck_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      time_q       <= time_d;
      best_q       <= best_d;
    end
  end

  assign game_state  = state_q;
  assign game_active = game_active_q;
  assign frame_tick  = frame_tick_q;
  assign jump_cmd    = jump_q;
  assign duck_cmd    = duck_q;
  assign cmd_src     = src_q;
  assign time_bcd    = time_q;
  assign best_bcd    = best_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Testbench for dino_game_ctrl: directed stimulus with hand-computed
// expectations pushed to a scoreboard queue, popped and compared by a
// separate monitor on the falling clock edge.
// A second instance with FRAMES_PER_SEC=1 exercises the BCD carries and the
// 99:59 saturation in a practical number of cycles.
module tb_dino_game_ctrl;

  logic        clk = 1'b0;
  logic        rst, vsync, start_pulse, pause_pulse;
  logic        btn_jump, btn_duck, kbd_jump, kbd_duck, sonic_en, collision;
  logic [19:0] distance;

  logic [1:0]  game_state, cmd_src;
  logic        game_active, frame_tick, jump_cmd, duck_cmd;
  logic [15:0] time_bcd, best_bcd;

  // Fast instance stimulus / outputs
  logic        vsync_f, start_f, zero;
  logic [19:0] zero20;
  logic [1:0]  game_state_f, cmd_src_f;
  logic        game_active_f, frame_tick_f, jump_cmd_f, duck_cmd_f;
  logic [15:0] time_bcd_f, best_bcd_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dino_game_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .start_pulse(start_pulse),
    .pause_pulse(pause_pulse), .btn_jump(btn_jump), .btn_duck(btn_duck),
    .kbd_jump(kbd_jump), .kbd_duck(kbd_duck), .distance(distance),
    .sonic_en(sonic_en), .collision(collision), .game_state(game_state),
    .game_active(game_active), .frame_tick(frame_tick), .jump_cmd(jump_cmd),
    .duck_cmd(duck_cmd), .cmd_src(cmd_src), .time_bcd(time_bcd),
    .best_bcd(best_bcd)
  );

  dino_game_ctrl #(.FRAMES_PER_SEC(1)) dut_fast (
    .clk(clk), .rst(rst), .vsync(vsync_f), .start_pulse(start_f),
    .pause_pulse(zero), .btn_jump(zero), .btn_duck(zero),
    .kbd_jump(zero), .kbd_duck(zero), .distance(zero20),
    .sonic_en(zero), .collision(zero), .game_state(game_state_f),
    .game_active(game_active_f), .frame_tick(frame_tick_f),
    .jump_cmd(jump_cmd_f), .duck_cmd(duck_cmd_f), .cmd_src(cmd_src_f),
    .time_bcd(time_bcd_f), .best_bcd(best_bcd_f)
  );

  typedef struct {
    string       name;
    bit          inst;
    logic [1:0]  st;
    logic        tick;
    logic        j;
    logic        d;
    logic [1:0]  src;
    logic [15:0] tm;
    logic [15:0] best;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: pop one expectation per falling edge and compare.
  always @(negedge clk) begin
    exp_t        e;
    logic [39:0] got, want;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst)
        got = {game_state_f, game_active_f, frame_tick_f, jump_cmd_f, duck_cmd_f,
               cmd_src_f, time_bcd_f, best_bcd_f};
      else
        got = {game_state, game_active, frame_tick, jump_cmd, duck_cmd,
               cmd_src, time_bcd, best_bcd};
      want = {e.st, (e.st == 2'd1), e.tick, e.j, e.d, e.src, e.tm, e.best};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got st=%0d act=%0d tick=%0d j=%0d d=%0d src=%0d time=%h best=%h ; want st=%0d act=%0d tick=%0d j=%0d d=%0d src=%0d time=%h best=%h",
                 e.name, got[39:38], got[37], got[36], got[35], got[34], got[33:32],
                 got[31:16], got[15:0], want[39:38], want[37], want[36], want[35],
                 want[34], want[33:32], want[31:16], want[15:0]);
      end
    end
  end

  task automatic expect_out(input string nm, input bit inst, input logic [1:0] st,
                            input logic tk, input logic j, input logic d,
                            input logic [1:0] src, input logic [15:0] tm,
                            input logic [15:0] bst);
    exp_t e;
    e.name = nm; e.inst = inst; e.st = st; e.tick = tk; e.j = j; e.d = d;
    e.src = src; e.tm = tm; e.best = bst;
    sb_q.push_back(e);
    @(negedge clk); #1;
  endtask

  // n frames on the main instance; returns with the last tick's results visible.
  task automatic frames(input int n);
    repeat (n) begin
      @(posedge clk); #1 vsync = 1'b1;
      @(posedge clk); #1 vsync = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic frames_f(input int n);
    repeat (n) begin
      @(posedge clk); #1 vsync_f = 1'b1;
      @(posedge clk); #1 vsync_f = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // One frame with collision / pause_pulse driven only in the tick cycle.
  task automatic evt_frame(input logic col, input logic pau);
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0; collision = col; pause_pulse = pau;
    @(posedge clk); #1 collision = 1'b0; pause_pulse = 1'b0;
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    @(posedge clk); #1 start_pulse = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_pulse = 1'b1;
    @(posedge clk); #1 pause_pulse = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vsync = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0;
    btn_jump = 1'b0; btn_duck = 1'b0; kbd_jump = 1'b0; kbd_duck = 1'b0;
    sonic_en = 1'b0; collision = 1'b0; distance = 20'd0;
    vsync_f = 1'b0; start_f = 1'b0; zero = 1'b0; zero20 = 20'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    expect_out("reset", 0, 2'd0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);

    // Frame tick in IDLE
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
    expect_out("tick_pulse", 0, 2'd0, 1, 0, 0, 2'd0, 16'h0000, 16'h0000);

    pulse_start();
    expect_out("idle_start", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);

    // Arbitration priority
    kbd_jump = 1'b1; btn_duck = 1'b1;
    frames(1);
    expect_out("btn_over_kbd", 0, 2'd1, 0, 0, 1, 2'd1, 16'h0000, 16'h0000);
    btn_duck = 1'b0;
    frames(1);
    expect_out("kbd_jump", 0, 2'd1, 0, 1, 0, 2'd2, 16'h0000, 16'h0000);
    kbd_jump = 1'b0; btn_jump = 1'b1; btn_duck = 1'b1;
    frames(1);
    expect_out("btn_both", 0, 2'd1, 0, 1, 0, 2'd1, 16'h0000, 16'h0000);
    btn_jump = 1'b0; btn_duck = 1'b0;

    // Sonic windows
    sonic_en = 1'b1; distance = 20'd5;
    frames(1);
    expect_out("sonic_5", 0, 2'd1, 0, 1, 0, 2'd3, 16'h0000, 16'h0000);
    distance = 20'd10;
    frames(1);
    expect_out("sonic_10", 0, 2'd1, 0, 0, 1, 2'd3, 16'h0000, 16'h0000);
    distance = 20'd25;
    frames(1);
    expect_out("sonic_25", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);
    distance = 20'd0;
    frames(1);
    expect_out("sonic_0", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);
    distance = 20'd24;
    frames(1);
    expect_out("sonic_24", 0, 2'd1, 0, 0, 1, 2'd3, 16'h0000, 16'h0000);
    distance = 20'd9;
    frames(1);
    expect_out("sonic_9", 0, 2'd1, 0, 1, 0, 2'd3, 16'h0000, 16'h0000);
    sonic_en = 1'b0; distance = 20'd5;
    frames(1);
    expect_out("sonic_disabled", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);
    sonic_en = 1'b1; kbd_duck = 1'b1;
    frames(1);
    expect_out("kbd_over_sonic", 0, 2'd1, 0, 0, 1, 2'd2, 16'h0000, 16'h0000);
    sonic_en = 1'b0; kbd_duck = 1'b0; distance = 20'd0;

    // 11 frames so far; 709 more makes 720 = 12 s
    frames(709);
    expect_out("time_12s", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0012, 16'h0000);

    // Collision beats same-cycle pause; commands forced off on entry
    btn_jump = 1'b1;
    evt_frame(1'b1, 1'b1);
    expect_out("collide_over", 0, 2'd3, 0, 0, 0, 2'd0, 16'h0012, 16'h0012);
    frames(2);
    expect_out("over_no_cmd", 0, 2'd3, 0, 0, 0, 2'd0, 16'h0012, 16'h0012);
    btn_jump = 1'b0;

    pulse_start();
    expect_out("over_start", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0000, 16'h0012);
    frames(300);
    expect_out("short_run", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0005, 16'h0012);
    evt_frame(1'b1, 1'b0);
    expect_out("best_kept", 0, 2'd3, 0, 0, 0, 2'd0, 16'h0005, 16'h0012);

    // Timer carries
    pulse_start();
    expect_out("restart", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0000, 16'h0012);
    frames(60);
    expect_out("time_1s", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0001, 16'h0012);
    frames(540);
    expect_out("time_10s", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0010, 16'h0012);
    frames(3000);
    expect_out("time_1min", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0100, 16'h0012);

    // Pause freezes everything
    btn_jump = 1'b1;
    frames(1);
    expect_out("pre_pause_cmd", 0, 2'd1, 0, 1, 0, 2'd1, 16'h0100, 16'h0012);
    pulse_pause();
    expect_out("pause_enter", 0, 2'd2, 0, 0, 0, 2'd0, 16'h0100, 16'h0012);
    collision = 1'b1;
    frames(120);
    collision = 1'b0;
    expect_out("pause_frozen", 0, 2'd2, 0, 0, 0, 2'd0, 16'h0100, 16'h0012);
    pulse_start();
    expect_out("pause_start_ign", 0, 2'd2, 0, 0, 0, 2'd0, 16'h0100, 16'h0012);
    btn_jump = 1'b0;
    pulse_pause();
    expect_out("pause_resume", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0100, 16'h0012);
    // One frame was counted before the pause: 58 more stays below the wrap.
    frames(58);
    expect_out("resume_59", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0100, 16'h0012);
    frames(1);
    expect_out("resume_wrap", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0101, 16'h0012);
    pulse_start();
    expect_out("run_start_ign", 0, 2'd1, 0, 0, 0, 2'd0, 16'h0101, 16'h0012);

    // Reset mid-run
    rst = 1'b1;
    @(posedge clk); #1;
    expect_out("rst_midrun", 0, 2'd0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);
    rst = 1'b0;

    // Fast instance: one tick per second
    start_f = 1'b1;
    @(posedge clk); #1 start_f = 1'b0;
    expect_out("fast_start", 1, 2'd1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000);
    frames_f(59);
    expect_out("fast_59s", 1, 2'd1, 0, 0, 0, 2'd0, 16'h0059, 16'h0000);
    frames_f(1);
    expect_out("fast_1min", 1, 2'd1, 0, 0, 0, 2'd0, 16'h0100, 16'h0000);
    frames_f(540);
    expect_out("fast_10min", 1, 2'd1, 0, 0, 0, 2'd0, 16'h1000, 16'h0000);
    frames_f(5399);
    expect_out("fast_9959", 1, 2'd1, 0, 0, 0, 2'd0, 16'h9959, 16'h0000);
    frames_f(10);
    expect_out("fast_saturate", 1, 2'd1, 0, 0, 0, 2'd0, 16'h9959, 16'h0000);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
